// File: rtl/pipelined_cla_adder_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
// Stage-count helper and add/sub mode encoding.
package pipelined_cla_adder_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int calc_ng(input int width, input int group_w);
        return width / group_w;
    endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUP_W-bit carry-lookahead group: sum, carry-out and
// the carry into its MSB (needed for signed overflow).
module cla_group #(
    parameter int GROUP_W = 4
) (
    input  logic [GROUP_W-1:0] i_x,
    input  logic [GROUP_W-1:0] i_y,
    input  logic               i_cin,
    output logic [GROUP_W-1:0] o_sum,
    output logic               o_cout,
    output logic               o_cmsb
);

    logic [GROUP_W-1:0] w_p;
    logic [GROUP_W-1:0] w_g;
    logic [GROUP_W:0]   w_c;

    // Every carry is a flat sum of generate/propagate products.
    function automatic logic [GROUP_W:0] lookahead(
        input logic [GROUP_W-1:0] p,
        input logic [GROUP_W-1:0] g,
        input logic               cin
    );
        logic [GROUP_W:0] c;
        logic             t;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < GROUP_W; i++) begin
            t = cin;
            for (int j = 0; j <= i; j++) t = t & p[j];
            c[i+1] = t;
            for (int j = 0; j <= i; j++) begin
                t = g[j];
                for (int m = j + 1; m <= i; m++) t = t & p[m];
                c[i+1] = c[i+1] | t;
            end
        end
        return c;
    endfunction

    assign w_p    = i_x ^ i_y;
    assign w_g    = i_x & i_y;
    assign w_c    = lookahead(w_p, w_g, i_cin);
    assign o_sum  = w_p ^ w_c[GROUP_W-1:0];
    assign o_cout = w_c[GROUP_W];
    assign o_cmsb = w_c[GROUP_W-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// WIDTH-bit add/sub pipeline, one lookahead group per stage,
// carry registered between stages, whole-pipe valid/ready stall.
module pipelined_cla_adder
    import pipelined_cla_adder_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int GROUP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NG = calc_ng(WIDTH, GROUP_W);

    if (GROUP_W < 1 || WIDTH < GROUP_W || (WIDTH % GROUP_W) != 0) begin : g_bad_cfg
        $error("pipelined_cla_adder: WIDTH must be a nonzero multiple of GROUP_W");
    end

    logic             w_adv;
    logic [WIDTH-1:0] w_b0;
    logic             w_c0;

    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;
    assign w_b0     = (in_sub == MODE_SUB) ? ~in_b : in_b;
    assign w_c0     = (in_sub == MODE_SUB) ? ~in_cin : in_cin;

    for (genvar k = 0; k < NG; k++) begin : g_stage
        // Operand bits still to be consumed, and sum bits produced so far.
        localparam int WK = WIDTH - k * GROUP_W;
        localparam int SK = (k + 1) * GROUP_W;

        logic [WK-1:0]      w_a;
        logic [WK-1:0]      w_b;
        logic               w_c;
        logic               w_v;
        logic [GROUP_W-1:0] w_gsum;
        logic               w_gcout;
        logic               w_cmsb;
        logic [SK-1:0]      w_s_next;

        logic               r_v;
        logic               r_c;
        logic [SK-1:0]      r_s;

        if (k == 0) begin : g_first
            assign w_a      = in_a;
            assign w_b      = w_b0;
            assign w_c      = w_c0;
            assign w_v      = in_valid;
            assign w_s_next = w_gsum;
        end else begin : g_next
            assign w_a      = g_stage[k-1].g_fwd.r_a;
            assign w_b      = g_stage[k-1].g_fwd.r_b;
            assign w_c      = g_stage[k-1].r_c;
            assign w_v      = g_stage[k-1].r_v;
            assign w_s_next = {w_gsum, g_stage[k-1].r_s};
        end

        cla_group #(.GROUP_W(GROUP_W)) u_grp (
            .i_x    (w_a[GROUP_W-1:0]),
            .i_y    (w_b[GROUP_W-1:0]),
            .i_cin  (w_c),
            .o_sum  (w_gsum),
            .o_cout (w_gcout),
            .o_cmsb (w_cmsb)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (w_adv) begin
                r_v <= w_v;
                r_c <= w_gcout;
                r_s <= w_s_next;
            end
        end

        if (k < NG - 1) begin : g_fwd
            logic [WK-GROUP_W-1:0] r_a;
            logic [WK-GROUP_W-1:0] r_b;
            logic                  w_unused_cmsb;

            assign w_unused_cmsb = w_cmsb;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_a[WK-1:GROUP_W];
                    r_b <= w_b[WK-1:GROUP_W];
                end
            end
        end else begin : g_last
            logic r_ovf;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= w_cmsb ^ w_gcout;
                end
            end
        end
    end

    assign out_valid = g_stage[NG-1].r_v;
    assign out_sum   = g_stage[NG-1].r_s;
    assign out_cout  = g_stage[NG-1].r_c;
    assign out_ovf   = g_stage[NG-1].g_last.r_ovf;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed cases on a 16-bit instance,
// randomized traffic on 16/8/32/4-bit instances against an integer model.
module tb_pipelined_cla_adder;

    localparam int NOPS = 10000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // {cout, ovf, sum} from plain integer arithmetic on a w-bit datapath.
    function automatic logic [33:0] ref_add(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input logic c,
                                            input logic sub);
        longint ua, ub, ur, sa, sb, sr, cc, lim, full;
        logic   cout, ovf;
        full = longint'(1) << w;
        lim  = longint'(1) << (w - 1);
        ua   = longint'(a);
        ub   = longint'(b);
        cc   = c ? 64'sd1 : 64'sd0;
        sa   = a[w-1] ? ua - full : ua;
        sb   = b[w-1] ? ub - full : ub;
        if (sub) begin
            ur   = ua - ub - cc;
            sr   = sa - sb - cc;
            cout = (ur >= 0);
        end else begin
            ur   = ua + ub + cc;
            sr   = sa + sb + cc;
            cout = (ur >= full);
        end
        ovf = (sr >= lim) || (sr < -lim);
        return {cout, ovf, 32'(ur & (full - 1))};
    endfunction

    logic        d_rst, d_iv, d_ir, d_cin, d_sub, d_ov, d_ordy, d_cout, d_ovf;
    logic [15:0] d_a, d_b, d_s;
    logic        rrst;

    pipelined_cla_adder #(.WIDTH(16), .GROUP_W(4)) u_dut (
        .clk(clk), .rst(d_rst),
        .in_valid(d_iv), .in_ready(d_ir),
        .in_a(d_a), .in_b(d_b), .in_cin(d_cin), .in_sub(d_sub),
        .out_valid(d_ov), .out_ready(d_ordy),
        .out_sum(d_s), .out_cout(d_cout), .out_ovf(d_ovf)
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_rnd
        localparam int W = (gi == 0) ? 16 : (gi == 1) ? 8 : (gi == 2) ? 32 : 4;

        logic         iv, ir, ov, ordy, cin, sub, cout, ovf, done;
        logic [W-1:0] a, b, s;

        pipelined_cla_adder #(.WIDTH(W), .GROUP_W(4)) u_dut (
            .clk(clk), .rst(rrst),
            .in_valid(iv), .in_ready(ir),
            .in_a(a), .in_b(b), .in_cin(cin), .in_sub(sub),
            .out_valid(ov), .out_ready(ordy),
            .out_sum(s), .out_cout(cout), .out_ovf(ovf)
        );

        initial begin
            logic [33:0] q[$];
            logic [33:0] e, hv;
            logic        held;
            int          sent;
            done = 1'b0; iv = 1'b0; ordy = 1'b0;
            a = '0; b = '0; cin = 1'b0; sub = 1'b0;
            sent = 0; held = 1'b0; hv = '0;
            @(negedge clk);
            while (rrst) @(negedge clk);
            for (int cyc = 0; cyc < NOPS * 6; cyc++) begin
                @(negedge clk);
                ordy = (sent >= NOPS) || ($urandom_range(0, 3) != 0);
                iv   = (sent < NOPS) && ($urandom_range(0, 3) != 0);
                a    = W'($urandom);
                b    = W'($urandom);
                cin  = 1'($urandom);
                sub  = 1'($urandom);
                #1;
                chk($sformatf("rnd%0d_ready", W), ir, !ov || ordy);
                if (held) chk($sformatf("rnd%0d_hold", W), {ov, cout, ovf, 32'(s)}, {1'b1, hv});
                if (ov && ordy) begin
                    if (q.size() == 0) begin
                        chk($sformatf("rnd%0d_extra", W), 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("rnd%0d_res", W), {cout, ovf, 32'(s)}, e);
                    end
                end
                held = ov && !ordy;
                hv   = {cout, ovf, 32'(s)};
                if (iv && ir) begin
                    q.push_back(ref_add(W, 32'(a), 32'(b), cin, sub));
                    sent++;
                end
                if (sent >= NOPS && q.size() == 0) break;
            end
            iv = 1'b0;
            chk($sformatf("rnd%0d_sent", W), sent, NOPS);
            chk($sformatf("rnd%0d_left", W), q.size(), 0);
            done = 1'b1;
        end
    end

    task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic c, input logic sub, input logic [15:0] es,
                           input logic ec, input logic eo);
        int lat;
        @(negedge clk);
        d_a = a; d_b = b; d_cin = c; d_sub = sub; d_iv = 1'b1; d_ordy = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        d_iv = 1'b0;
        while (!d_ov && lat < 12) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_sum"}, d_s, es);
        chk({tag, "_cout"}, d_cout, ec);
        chk({tag, "_ovf"}, d_ovf, eo);
    endtask

    initial begin
        logic [33:0] bq[$];
        logic [33:0] hold, e;
        logic [15:0] oa, ob;
        logic        stall;
        int          nsent, nrecv, seen;
        bit          all_done;

        d_rst = 1'b1; rrst = 1'b1;
        d_iv = 1'b0; d_ordy = 1'b0; d_a = '0; d_b = '0; d_cin = 1'b0; d_sub = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid", d_ov, 0);
        chk("reset_sum", d_s, 0);
        chk("reset_cout", d_cout, 0);
        chk("reset_ovf", d_ovf, 0);
        chk("reset_ready", d_ir, 1);
        d_rst = 1'b0; rrst = 1'b0;

        run_one("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_one("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_one("ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_one("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_one("sub_brw", 16'h0009, 16'h0004, 1'b1, 1'b1, 16'h0004, 1'b1, 1'b0);

        nsent = 0; nrecv = 0; hold = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            stall  = (cyc >= 6) && (cyc <= 8);
            d_ordy = !stall;
            d_iv   = (nsent < 8);
            oa     = 16'(nsent * 16'h2345);
            ob     = 16'hFFFF - 16'(nsent * 16'h0111);
            d_a = oa; d_b = ob; d_sub = nsent[0]; d_cin = nsent[1];
            #1;
            chk("bp_ready", d_ir, !stall);
            if (cyc == 6) begin
                chk("bp_full", d_ov, 1);
                hold = {d_cout, d_ovf, 16'h0, d_s};
            end else if (stall) begin
                chk("bp_hold", {d_ov, d_cout, d_ovf, 16'h0, d_s}, {1'b1, hold});
            end
            if (d_ov && d_ordy) begin
                if (bq.size() == 0) begin
                    chk("bp_extra", 1, 0);
                end else begin
                    e = bq.pop_front();
                    chk("bp_res", {d_cout, d_ovf, 16'h0, d_s}, e);
                end
                nrecv++;
            end
            if (d_iv && d_ir) begin
                bq.push_back(ref_add(16, 32'(oa), 32'(ob), d_cin, d_sub));
                nsent++;
            end
            if (nrecv == 8) break;
        end
        d_iv = 1'b0;
        chk("bp_count", nrecv, 8);

        @(negedge clk);
        d_ordy = 1'b1; d_iv = 1'b1; d_a = 16'h1111; d_b = 16'h2222; d_cin = 1'b0; d_sub = 1'b0;
        @(negedge clk);
        d_a = 16'h3333;
        @(negedge clk);
        d_a = 16'h5555;
        d_rst = 1'b1;
        #1;
        chk("rst_valid", d_ov, 0);
        chk("rst_ready", d_ir, 1);
        chk("rst_sum", d_s, 0);
        @(negedge clk);
        d_rst = 1'b0; d_iv = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (d_ov) seen++;
        end
        chk("rst_stray", seen, 0);
        run_one("post_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

        all_done = 1'b0;
        for (int cyc = 0; cyc < 90000 && !all_done; cyc++) begin
            @(posedge clk);
            all_done = g_rnd[0].done && g_rnd[1].done && g_rnd[2].done && g_rnd[3].done;
        end
        chk("rnd_done", all_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
